// File: rtl/framebuffer_fetch_multi.sv
// framebuffer_fetch_multi: fetches one pixel per pane from RAM and publishes all panes together
module framebuffer_fetch_multi #(
  parameter int COL_BITS    = 6,
  parameter int ROW_BITS    = 4,
  parameter int PANE_BITS   = 1,
  parameter int PIXEL_WIDTH = 16,
  parameter int RAM_LATENCY = 2
) (
  input  logic                                   clk_in,
  input  logic                                   reset_n,
  input  logic [COL_BITS-1:0]                    column_address,
  input  logic [ROW_BITS-1:0]                    row_address,
  input  logic                                   mirror,
  input  logic                                   start,
  input  logic [PIXEL_WIDTH-1:0]                 ram_data_in,
  output logic [PANE_BITS+ROW_BITS+COL_BITS-1:0] ram_addr,
  output logic                                   ram_clk_enable,
  output logic                                   ram_reset,
  output logic [(2**PANE_BITS)*PIXEL_WIDTH-1:0]  pixels_out,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overrun
);
  localparam int PANES = 2 ** PANE_BITS;
  localparam int AW = PANE_BITS + ROW_BITS + COL_BITS;
  localparam int PB = PANE_BITS > 0 ? PANE_BITS : 1;
  localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY > 1 ? RAM_LATENCY - 2 : 0);
  localparam logic [PB-1:0] PANE_LAST = PB'(PANES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, DONE} state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [PB-1:0] pane_q, pane_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic mir_q, mir_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [PANES-1:0][PIXEL_WIDTH-1:0] slot_q, slot_d, pix_q, pix_d;
  logic done_q, done_d, ovr_q, ovr_d;
  logic accept;

  // With a single pane the pane bit is dropped by the final truncation
  function automatic logic [AW-1:0] mk_addr(input logic [PB-1:0] p, input logic [ROW_BITS-1:0] r,
                                            input logic [COL_BITS-1:0] c, input logic m);
    logic [PB+ROW_BITS+COL_BITS-1:0] full;
    full = {p, r, m ? ~c : c};
    return full[AW-1:0];
  endfunction

  assign busy           = state_q == ADDR || state_q == WAIT || state_q == LATCH;
  assign accept         = start && (state_q == IDLE || state_q == DONE);
  assign ram_clk_enable = busy;
  assign ram_reset      = ~reset_n;
  assign ram_addr       = addr_q;
  assign pixels_out     = pix_q;
  assign done           = done_q;
  assign overrun        = ovr_q;

  // Sequencer: one address/wait/latch round per pane, then a single publish cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pane_d  = pane_q;
    row_d   = row_q;
    col_d   = col_q;
    mir_d   = mir_q;
    addr_d  = addr_q;
    slot_d  = slot_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    ovr_d   = busy && start ? 1'b1 : ovr_q;
    case (state_q)
      ADDR: begin
        pane_d  = pane_q + 1'b1;
        addr_d  = mk_addr(pane_q + 1'b1, row_q, col_q, mir_q);
        cnt_d   = '0;
        state_d = RAM_LATENCY == 1 ? LATCH : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == WAIT_LAST ? LATCH : WAIT;
      end
      LATCH: begin
        slot_d[pane_q] = ram_data_in;
        state_d = pane_q == PANE_LAST ? DONE : ADDR;
      end
      DONE: begin
        pix_d   = slot_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      row_d   = row_address;
      col_d   = column_address;
      mir_d   = mirror;
      pane_d  = '0;
      cnt_d   = '0;
      addr_d  = mk_addr('0, row_address, column_address, mirror);
      ovr_d   = 1'b0;
      state_d = RAM_LATENCY == 1 ? LATCH : WAIT;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pane_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mir_q   <= 1'b0;
      addr_q  <= '0;
      slot_q  <= '0;
      pix_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pane_q  <= pane_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mir_q   <= mir_d;
      addr_q  <= addr_d;
      slot_q  <= slot_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_framebuffer_fetch_multi.sv
// tb_framebuffer_fetch_multi: directed vector bench for the default and a four-pane build
module tb_framebuffer_fetch_multi;
  logic clk = 1'b0, reset_n = 1'b1, mirror = 1'b0, start = 1'b0;
  logic [3:0] row = '0;
  logic [5:0] col = '0;
  logic [10:0] ram_addr;
  logic [11:0] ram_addr4;
  logic [15:0] ram_data, ram_data4, r4a;
  logic [31:0] pix;
  logic [63:0] pix4;
  logic rce, rrst, busy, done, ovr, rce4, rrst4, busy4, done4, ovr4;
  int checks = 0, errors = 0;
  logic [31:0] last_pix = '0;

  typedef struct {
    logic [3:0]  row;
    logic [5:0]  col;
    logic        m;
    logic [10:0] a0;
    logic [10:0] a1;
    logic [31:0] pix;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  framebuffer_fetch_multi dut (
    .clk_in(clk), .reset_n(reset_n), .column_address(col), .row_address(row), .mirror(mirror),
    .start(start), .ram_data_in(ram_data), .ram_addr(ram_addr), .ram_clk_enable(rce),
    .ram_reset(rrst), .pixels_out(pix), .busy(busy), .done(done), .overrun(ovr));

  framebuffer_fetch_multi #(.PANE_BITS(2), .RAM_LATENCY(3)) dut4 (
    .clk_in(clk), .reset_n(reset_n), .column_address(col), .row_address(row), .mirror(mirror),
    .start(start), .ram_data_in(ram_data4), .ram_addr(ram_addr4), .ram_clk_enable(rce4),
    .ram_reset(rrst4), .pixels_out(pix4), .busy(busy4), .done(done4), .overrun(ovr4));

  // RAM models: word = 0xA000 ^ address, latency 2 and 3 clocks
  always_ff @(posedge clk) begin
    ram_data  <= 16'hA000 ^ 16'(ram_addr);
    r4a       <= 16'hA000 ^ 16'(ram_addr4);
    ram_data4 <= r4a;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fetch(input vec_t v);
    row = v.row; col = v.col; mirror = v.m; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; row = ~v.row; col = ~v.col; mirror = ~v.m;
    chk("addr_pane0", 64'(ram_addr), 64'(v.a0));
    chk("busy", 64'(busy), 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) chk("addr_pane1", 64'(ram_addr), 64'(v.a1));
      if (k < 6) begin
        chk("done_early", 64'(done), 0);
        chk("pix_hold", 64'(pix), 64'(last_pix));
      end
      if (k == 6) begin
        chk("done_edge", 64'(done), 1);
        chk("pix_done", 64'(pix), 64'(v.pix));
      end
      if (k == 7) begin
        chk("done_pulse", 64'(done), 0);
        chk("idle_busy", 64'(busy), 0);
        chk("addr_hold", 64'(ram_addr), 64'(v.a1));
      end
    end
    last_pix = v.pix;
  endtask

  initial begin
    vecs[0] = '{4'd5,  6'd3,  1'b1, 11'h17C, 11'h57C, 32'hA57C_A17C};
    vecs[1] = '{4'd5,  6'd3,  1'b0, 11'h143, 11'h543, 32'hA543_A143};
    vecs[2] = '{4'd0,  6'd0,  1'b0, 11'h000, 11'h400, 32'hA400_A000};
    vecs[3] = '{4'd15, 6'd63, 1'b1, 11'h3C0, 11'h7C0, 32'hA7C0_A3C0};
    vecs[4] = '{4'd15, 6'd63, 1'b0, 11'h3FF, 11'h7FF, 32'hA7FF_A3FF};

    #2 reset_n = 1'b0;
    #1;
    chk("rst_addr", 64'(ram_addr), 0);
    chk("rst_pix", 64'(pix), 0);
    chk("rst_flags", {60'd0, busy, done, ovr, rce}, 0);
    chk("rst_ram_reset", 64'(rrst), 1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ram_reset_rel", 64'(rrst), 0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) fetch(vecs[i]);

    // start repeated mid-fetch with changed inputs: overrun, fetch untouched
    row = 4'd5; col = 6'd3; mirror = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; row = 4'd9; col = 6'd1; mirror = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("overrun_set", 64'(ovr), 1);
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) chk("ovr_addr1", 64'(ram_addr), 64'h57C);
      if (k != 6) chk("ovr_done_only_once", 64'(done), 0);
      if (k == 6) chk("ovr_pix", 64'(pix), 64'hA57C_A17C);
    end
    chk("overrun_sticky", 64'(ovr), 1);
    last_pix = 32'hA57C_A17C;
    row = vecs[1].row; col = vecs[1].col; mirror = vecs[1].m; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("overrun_clear", 64'(ovr), 0);
    repeat (7) @(negedge clk);
    last_pix = vecs[1].pix;

    // back-to-back: second start lands in the DONE cycle
    row = vecs[3].row; col = vecs[3].col; mirror = vecs[3].m; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        row = vecs[4].row; col = vecs[4].col; mirror = vecs[4].m; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (k == 6) begin
        chk("b2b_done1", 64'(done), 1);
        chk("b2b_pix1", 64'(pix), 64'(vecs[3].pix));
        chk("b2b_addr2", 64'(ram_addr), 64'(vecs[4].a0));
        chk("b2b_busy", 64'(busy), 1);
        chk("b2b_no_ovr", 64'(ovr), 0);
      end else if (k == 12) begin
        chk("b2b_done2", 64'(done), 1);
        chk("b2b_pix2", 64'(pix), 64'(vecs[4].pix));
      end else chk("b2b_gap", 64'(done), 0);
    end
    last_pix = vecs[4].pix;
    @(negedge clk);

    // reset in the middle of a fetch
    row = vecs[2].row; col = vecs[2].col; mirror = vecs[2].m; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_addr", 64'(ram_addr), 0);
    chk("mid_rst_pix", 64'(pix), 0);
    chk("mid_rst_flags", {60'd0, busy, done, ovr, rce}, 0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_done", 64'(done), 0);
    end
    reset_n = 1'b1;
    last_pix = '0;
    @(negedge clk);
    fetch(vecs[0]);

    // four panes, latency 3
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    row = 4'd5; col = 6'd3; mirror = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("p4_addr0", 64'(ram_addr4), 64'h17C);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 4) chk("p4_addr1", 64'(ram_addr4), 64'h57C);
      if (k == 8) chk("p4_addr2", 64'(ram_addr4), 64'h97C);
      if (k == 12) chk("p4_addr3", 64'(ram_addr4), 64'hD7C);
      if (k < 16) chk("p4_pix_hold", pix4, 0);
      if (k == 15) chk("p4_not_done", 64'(done4), 0);
      if (k == 16) begin
        chk("p4_done", 64'(done4), 1);
        chk("p4_pix", pix4, 64'hAD7C_A97C_A57C_A17C);
      end
      if (k == 17) chk("p4_idle", {62'd0, busy4, done4}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
